// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and helpers for the multicycle ALU.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SLL = 4'd3;
  localparam logic [3:0] OP_SRL = 4'd4;
  localparam logic [3:0] OP_SRA = 4'd5;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative datapath: one shift or one shift-add multiply step per cycle,
// paced by a down-counter whose terminal count ends the operation.
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CW    = 5
) (
  input  logic                 clk_sys_i,
  input  logic                 rst_b_i,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic [3:0]           op_i,
  input  logic [CW-1:0]        cnt_init_i,
  input  logic [WIDTH-1:0]     x_i,
  input  logic [WIDTH-1:0]     y_i,
  output logic                 cnt_zero_o,
  output logic [WIDTH-1:0]     shift_o,
  output logic [2*WIDTH-1:0]   prod_o
);

  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   sh_q, sh_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]     partial;

  // Accumulator low half starts as the multiplier and drains out as the
  // product shifts in from the top.
  always_comb begin
    partial = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    if (load_i) begin
      cnt_d   = cnt_init_i;
      sh_d    = x_i;
      mcand_d = x_i;
      acc_d   = {{WIDTH{1'b0}}, y_i};
    end else if (step_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
      case (op_i)
        OP_SLL:  sh_d  = {sh_q[WIDTH-2:0], 1'b0};
        OP_SRL:  sh_d  = {1'b0, sh_q[WIDTH-1:1]};
        OP_SRA:  sh_d  = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
        OP_MUL:  acc_d = {partial, acc_q[WIDTH-1:1]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_sys_i or negedge rst_b_i) begin
    if (!rst_b_i) begin
      cnt_q   <= '0;
      sh_q    <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
    end
  end

  assign cnt_zero_o = (cnt_q == '0);
  assign shift_o    = sh_q;
  assign prod_o     = acc_q;

endmodule

// File: rtl/alu_multicycle.sv
// Multicycle ALU with Start/Busy/Done handshake and registered result/flags.
//   state | meaning
//   IDLE  | waiting for Start; outputs hold the last result
//   RUN   | operands latched; iterating until the counter reaches zero
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             CLK,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [3:0]       ALUct1,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Flip,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] ALUOut,
  output logic             Zero,
  output logic             Overflow
);

  localparam int LW = clog2(WIDTH);
  localparam int CW = LW + 1;

  state_e             state_q, state_d;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   x_q, y_q, x_in, y_in;
  logic [WIDTH-1:0]   out_q, out_d;
  logic               zero_q, ovf_q, ovf_d, done_q, done_d;
  logic               accept, finish, cnt_zero;
  logic [CW-1:0]      cnt_init;
  logic [WIDTH-1:0]   shift_res, sum, diff;
  logic [2*WIDTH-1:0] prod;

  assign x_in   = Flip ? B : A;
  assign y_in   = Flip ? A : B;
  assign accept = (state_q == IDLE) && Start;
  assign finish = (state_q == RUN) && cnt_zero;

  always_comb begin
    cnt_init = '0;
    case (ALUct1)
      OP_SLL, OP_SRL, OP_SRA: cnt_init = CW'(y_in[LW-1:0]);
      OP_MUL:                 if (MUL_EN) cnt_init = CW'(WIDTH);
      default:                cnt_init = '0;
    endcase
  end

  alu_iter_unit #(.WIDTH(WIDTH), .CW(CW)) u_iter (
    .clk_sys_i  (CLK),
    .rst_b_i    (Reset_n),
    .load_i     (accept),
    .step_i     (state_q == RUN),
    .op_i       (op_q),
    .cnt_init_i (cnt_init),
    .x_i        (x_in),
    .y_i        (y_in),
    .cnt_zero_o (cnt_zero),
    .shift_o    (shift_res),
    .prod_o     (prod)
  );

  assign sum  = x_q + y_q;
  assign diff = x_q - y_q;

  // SLT uses a true signed compare so an overflowing X-Y cannot flip the answer.
  always_comb begin
    out_d = '0;
    ovf_d = 1'b0;
    case (op_q)
      OP_AND: out_d = x_q & y_q;
      OP_OR:  out_d = x_q | y_q;
      OP_ADD: begin
        out_d = sum;
        ovf_d = (x_q[WIDTH-1] == y_q[WIDTH-1]) && (sum[WIDTH-1] != x_q[WIDTH-1]);
      end
      OP_SUB: begin
        out_d = diff;
        ovf_d = (x_q[WIDTH-1] != y_q[WIDTH-1]) && (diff[WIDTH-1] != x_q[WIDTH-1]);
      end
      OP_SLT: out_d = {{(WIDTH-1){1'b0}}, ($signed(x_q) < $signed(y_q))};
      OP_SLL, OP_SRL, OP_SRA: out_d = shift_res;
      OP_MUL: if (MUL_EN) begin
        out_d = prod[WIDTH-1:0];
        ovf_d = |prod[2*WIDTH-1:WIDTH];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (Start) state_d = RUN;
      RUN: if (cnt_zero) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      op_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      out_q   <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (accept) begin
        op_q <= ALUct1;
        x_q  <= x_in;
        y_q  <= y_in;
      end
      if (finish) begin
        out_q  <= out_d;
        zero_q <= (out_d == '0);
        ovf_q  <= ovf_d;
      end
    end
  end

  assign Busy     = (state_q == RUN);
  assign Done     = done_q;
  assign ALUOut   = out_q;
  assign Zero     = zero_q;
  assign Overflow = ovf_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle: driver pushes model results, monitor checks at Done.
module tb_alu_multicycle;

  logic        CLK = 1'b0;
  logic        Reset_n = 1'b1;
  logic        Start = 1'b0;
  logic        Flip = 1'b0;
  logic [3:0]  ALUct1 = 4'd0;
  logic [15:0] A = 16'd0;
  logic [15:0] B = 16'd0;
  logic        Busy, Done, Zero, Overflow;
  logic [15:0] ALUOut;

  alu_multicycle #(.WIDTH(16), .MUL_EN(1'b1)) dut (
    .CLK(CLK), .Reset_n(Reset_n), .Start(Start), .ALUct1(ALUct1),
    .A(A), .B(B), .Flip(Flip), .Busy(Busy), .Done(Done),
    .ALUOut(ALUOut), .Zero(Zero), .Overflow(Overflow)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] out;
    logic        zero;
    logic        ovf;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
  endtask

  // Reference: plain integer arithmetic on the architectural definition.
  function automatic exp_t model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                 input logic flip);
    exp_t m;
    logic [15:0] x, y;
    int sx, sy, r, sh;
    longint unsigned p;
    x = flip ? b : a;
    y = flip ? a : b;
    sx = int'($signed(x));
    sy = int'($signed(y));
    sh = int'(y) % 16;
    m.op = op; m.out = 16'd0; m.ovf = 1'b0; m.lat = 1; m.acc = 0;
    case (op)
      4'd0: m.out = x & y;
      4'd1: m.out = x | y;
      4'd2: begin r = sx + sy; m.out = 16'(r); m.ovf = (r > 32767) || (r < -32768); end
      4'd6: begin r = sx - sy; m.out = 16'(r); m.ovf = (r > 32767) || (r < -32768); end
      4'd7: m.out = (sx < sy) ? 16'd1 : 16'd0;
      4'd3: begin p = longint'(x) << sh; m.out = 16'(p); m.lat = sh + 1; end
      4'd4: begin m.out = x >> sh; m.lat = sh + 1; end
      4'd5: begin r = sx >>> sh; m.out = 16'(r); m.lat = sh + 1; end
      4'd8: begin
        p = longint'(x) * longint'(y);
        m.out = 16'(p);
        m.ovf = (p >> 16) != 0;
        m.lat = 17;
      end
      default: m.out = 16'd0;
    endcase
    m.zero = (m.out == 16'd0);
    return m;
  endfunction

  always @(negedge CLK) begin
    if (Reset_n && Done) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_done: got Done=1 expected no pending op (t=%0t)", $time);
      end else begin
        mon_e = sb.pop_front();
        check($sformatf("aluout_op%0d", mon_e.op), 32'(ALUOut), 32'(mon_e.out));
        check($sformatf("zero_op%0d", mon_e.op), 32'(Zero), 32'(mon_e.zero));
        check($sformatf("ovf_op%0d", mon_e.op), 32'(Overflow), 32'(mon_e.ovf));
        check($sformatf("latency_op%0d", mon_e.op), 32'(cyc - mon_e.acc), 32'(mon_e.lat));
      end
    end
  end

  // Drive on the current negedge; operands are scrambled after acceptance.
  task automatic drive_now(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic flip);
    exp_t e;
    ALUct1 = op; A = a; B = b; Flip = flip; Start = 1'b1;
    @(posedge CLK); #1;
    e = model(op, a, b, flip);
    e.acc = cyc;
    sb.push_back(e);
    Start = 1'b0;
    A = 16'($urandom); B = 16'($urandom);
    Flip = 1'($urandom); ALUct1 = 4'($urandom);
  endtask

  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic flip);
    int guard;
    guard = 0;
    @(negedge CLK);
    while (Busy && guard < 100) begin @(negedge CLK); guard++; end
    if (Busy) begin
      checks++;
      $display("FAIL issue_timeout: got Busy=1 expected Busy=0 within 100 cycles");
    end else drive_now(op, a, b, flip);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 200) begin @(negedge CLK); guard++; end
    if (sb.size() != 0) begin
      checks++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int guard;
    int bad;
    #2 Reset_n = 1'b0;
    #1;
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_aluout", 32'(ALUOut), 32'd0);
    check("rst_flags", 32'({Zero, Overflow}), 32'd0);
    repeat (2) @(negedge CLK);
    Reset_n = 1'b1;

    issue(4'd2, 16'h7FFF, 16'h0001, 1'b0);
    issue(4'd2, 16'hFFFF, 16'h0001, 1'b0);
    issue(4'd6, 16'h0005, 16'h0003, 1'b1);
    issue(4'd7, 16'h8000, 16'h0001, 1'b0);
    issue(4'd7, 16'h8000, 16'h0001, 1'b1);
    issue(4'd5, 16'h8000, 16'h0004, 1'b0);
    issue(4'd5, 16'h8000, 16'h0010, 1'b0);
    issue(4'd3, 16'h0001, 16'h000F, 1'b0);
    issue(4'd8, 16'h0003, 16'h0005, 1'b0);
    issue(4'd8, 16'h0100, 16'h0100, 1'b0);
    drain();

    // Start while busy is ignored; Start in the Done cycle is accepted.
    issue(4'd8, 16'h1234, 16'h0077, 1'b0);
    @(negedge CLK);
    ALUct1 = 4'd2; A = 16'h0001; B = 16'h0001; Start = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      check("busy_hold", 32'(Busy), 32'd1);
    end
    Start = 1'b0;
    guard = 0;
    while (!Done && guard < 40) begin @(negedge CLK); guard++; end
    check("done_seen", 32'(Done), 32'd1);
    check("done_cycle_idle", 32'(Busy), 32'd0);
    drive_now(4'd0, 16'h00F0, 16'h0FF0, 1'b0);
    issue(4'd12, 16'h1234, 16'h5678, 1'b0);
    drain();

    // Reset in the middle of a multiply.
    issue(4'd8, 16'hABCD, 16'h1234, 1'b0);
    repeat (6) @(posedge CLK);
    #2 Reset_n = 1'b0;
    #1;
    sb.delete();
    check("midrst_busy", 32'(Busy), 32'd0);
    check("midrst_done", 32'(Done), 32'd0);
    check("midrst_aluout", 32'(ALUOut), 32'd0);
    check("midrst_flags", 32'({Zero, Overflow}), 32'd0);
    repeat (2) @(negedge CLK);
    Reset_n = 1'b1;
    bad = 0;
    repeat (25) begin
      @(negedge CLK);
      if (Done || Busy) bad++;
    end
    check("post_rst_quiet", 32'(bad), 32'd0);
    issue(4'd2, 16'h1111, 16'h2222, 1'b0);
    drain();

    for (int i = 0; i < 60; i++) begin
      logic [3:0] op;
      op = (i % 4 == 0) ? 4'd8 : 4'($urandom_range(0, 15));
      issue(op, 16'($urandom), 16'($urandom), 1'($urandom));
    end
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
